// File: rtl/distributor_fixed_shiftable_if.sv
// Stream bundle between one producer and N lane consumers of the distributor.
// The distributor itself takes the slave view; the driving side takes master.
interface distributor_fixed_shiftable_if #(
    parameter int DWIDTH = 20,
    parameter int N      = 2
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              shift;
    logic              out_valid [N-1:0];
    logic [DWIDTH-1:0] out_data  [N-1:0];
    logic              out_ready [N-1:0];

    modport master (
        output in_valid, in_data, shift, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, shift, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/distributor_fixed_shiftable.sv
// 1-to-N stream distributor with rotating fixed priority and one-entry lane buffers.
// Define DISTRIBUTOR_STATS_EN to add per-lane saturating load counters (lane_count).
module distributor_fixed_shiftable_lane #(
    parameter int DWIDTH = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [DWIDTH-1:0] in_data,
    output logic              vld,
    output logic [DWIDTH-1:0] dat
);
    logic              vld_q, vld_d;
    logic [DWIDTH-1:0] dat_q, dat_d;

    // A load wins over a drain, so a lane emptied this cycle refills without a bubble.
    always_comb begin
        vld_d = load | (vld_q & ~drain);
        dat_d = load ? in_data : dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;
endmodule

module distributor_fixed_shiftable #(
    parameter int DWIDTH           = 20,
    parameter int N                = 2,
    parameter int INIT_LOWEST_PRIO = N - 1
) (
    input  logic clk,
    input  logic rst,
    distributor_fixed_shiftable_if.slave bus
`ifdef DISTRIBUTOR_STATS_EN
    ,
    output logic [15:0] lane_count [N-1:0]
`endif
);
    localparam int LPW = $clog2(N);

    logic [LPW-1:0] lp_q, lp_d;
    logic [LPW-1:0] sel;
    logic [LPW-1:0] cand;
    logic           found;
    logic           accept;
    logic [N-1:0]   avail, load, vld;
    logic [N-1:0][DWIDTH-1:0] dat;

    // Scan from lp+1 around to lp; the first available lane takes the beat.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = LPW'((int'(lp_q) + k) % N);
            if (!found && avail[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign bus.in_ready = ~rst & (|avail);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        lp_d = lp_q;
        if (bus.shift)
            lp_d = (lp_q == LPW'(N - 1)) ? '0 : lp_q + LPW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) lp_q <= LPW'(INIT_LOWEST_PRIO);
        else     lp_q <= lp_d;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign avail[i] = ~vld[i] | bus.out_ready[i];
        assign load[i]  = accept & (sel == LPW'(i));

        distributor_fixed_shiftable_lane #(.DWIDTH(DWIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .drain   (bus.out_ready[i]),
            .in_data (bus.in_data),
            .vld     (vld[i]),
            .dat     (dat[i])
        );

        assign bus.out_valid[i] = vld[i];
        assign bus.out_data[i]  = dat[i];
    end

`ifdef DISTRIBUTOR_STATS_EN
    logic [15:0] cnt_q [N-1:0];
    logic [15:0] cnt_d [N-1:0];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cnt
        assign lane_count[i] = cnt_q[i];
    end
`endif
endmodule

// File: tb/tb_distributor_fixed_shiftable.sv
// Randomized scoreboard bench for distributor_fixed_shiftable (N=4, lowest prio lane 3 after reset).
module tb_distributor_fixed_shiftable;
    localparam int DW   = 20;
    localparam int N    = 4;
    localparam int INIT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    distributor_fixed_shiftable_if #(.DWIDTH(DW), .N(N)) bus ();
`ifdef DISTRIBUTOR_STATS_EN
    logic [15:0] lane_count [N-1:0];
`endif

    distributor_fixed_shiftable #(.DWIDTH(DW), .N(N), .INIT_LOWEST_PRIO(INIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DISTRIBUTOR_STATS_EN
        ,
        .lane_count (lane_count)
`endif
    );

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Model: per-lane queue of beats currently buffered in that lane, plus the pointer.
    logic [DW-1:0] expq [N][$];
    int            mlp = INIT;
    int            mcnt [N];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit sh,
                         input logic [N-1:0] rdy, input bit r);
        int lane;
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.shift    = sh;
        for (int i = 0; i < N; i++) bus.out_ready[i] = rdy[i];
        #1;
        lane = -1;
        if (!r) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mlp + k) % N;
                if (lane < 0 && (expq[c].size() == 0 || rdy[c])) lane = c;
            end
        end
        if (mon_en) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, lane >= 0});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) begin
                expq[i].delete();
                mcnt[i] = 0;
            end
            mlp = INIT;
        end else begin
            if (v && lane >= 0) begin
                expq[lane].push_back(d);
                if (mcnt[lane] < 16'hFFFF) mcnt[lane]++;
            end
            if (sh) mlp = (mlp + 1) % N;
        end
    endtask

    // Monitor: checks each lane against the model and retires beats on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("out_valid[%0d]", i), {31'd0, bus.out_valid[i]},
                        {31'd0, expq[i].size() != 0});
                    if (bus.out_valid[i] && expq[i].size() != 0) begin
                        chk($sformatf("out_data[%0d]", i), 32'(bus.out_data[i]), 32'(expq[i][0]));
                        if (bus.out_ready[i]) void'(expq[i].pop_front());
                    end
`ifdef DISTRIBUTOR_STATS_EN
                    chk($sformatf("lane_count[%0d]", i), 32'(lane_count[i]), 32'(mcnt[i]));
`endif
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.shift    = 1'b0;
        for (int i = 0; i < N; i++) bus.out_ready[i] = 1'b0;
        cycle(0, 0, 0, 4'b0000, 1);
        cycle(0, 0, 0, 4'b0000, 1);
        mon_en = 1'b1;

        // Reset priority: first beat lands in lane 0.
        cycle(1, 20'h11, 0, 4'b1111, 0);
        #1;
        chk("rst_prio_vld0", {31'd0, bus.out_valid[0]}, 32'd1);
        chk("rst_prio_dat0", 32'(bus.out_data[0]), 32'h11);
        cycle(0, 0, 0, 4'b1111, 0);

        // Fill order with stalled consumers, then 0xE waits for lane 2.
        for (int b = 0; b < 5; b++) cycle(1, 20'(32'hA + b), 0, 4'b0000, 0);
        cycle(1, 20'hE, 0, 4'b0000, 0);
        #1;
        chk("fill_dat3", 32'(bus.out_data[3]), 32'hD);
        chk("fill_full_ready", {31'd0, bus.in_ready}, 32'd0);
        cycle(1, 20'hE, 0, 4'b0100, 0);
        #1;
        chk("fill_reload_dat2", 32'(bus.out_data[2]), 32'hE);
        cycle(0, 0, 0, 4'b1111, 0);

        // Shift in the same cycle as a transfer uses the old pointer.
        cycle(1, 20'h5, 1, 4'b1111, 0);
        #1;
        chk("shift_dat0", 32'(bus.out_data[0]), 32'h5);
        cycle(1, 20'h6, 0, 4'b1111, 0);
        #1;
        chk("shift_dat1", 32'(bus.out_data[1]), 32'h6);
        for (int s = 0; s < 3; s++) cycle(0, 0, 1, 4'b1111, 0);

        // Same-cycle drain and reload on the only free lane.
        for (int b = 0; b < 4; b++) cycle(1, 20'(32'h100 + b), 0, 4'b0000, 0);
        cycle(1, 20'h2, 0, 4'b0001, 0);
        #1;
        chk("reload_vld0", {31'd0, bus.out_valid[0]}, 32'd1);
        chk("reload_dat0", 32'(bus.out_data[0]), 32'h2);

        // Reset mid-stream discards buffered beats and restores the pointer.
        cycle(0, 0, 1, 4'b0000, 1);
        #1;
        for (int i = 0; i < N; i++)
            chk("midrst_vld", {31'd0, bus.out_valid[i]}, 32'd0);
        cycle(1, 20'h77, 0, 4'b0000, 0);
        #1;
        chk("midrst_lane", {31'd0, bus.out_valid[(INIT + 1) % N]}, 32'd1);
        chk("midrst_dat", 32'(bus.out_data[(INIT + 1) % N]), 32'h77);

        // Random traffic with occasional shifts and resets.
        for (int c = 0; c < 4000; c++)
            cycle($urandom_range(0, 3) != 0, 20'($urandom), $urandom_range(0, 7) == 0,
                  4'($urandom), $urandom_range(0, 199) == 0);

`ifdef DISTRIBUTOR_STATS_EN
        // Saturation: with every lane always free, all beats go to lane 0.
        cycle(0, 0, 0, 4'b1111, 1);
        for (int c = 0; c < 70000; c++) cycle(1, 20'(c), 0, 4'b1111, 0);
        #1;
        chk("stats_sat", 32'(lane_count[0]), 32'hFFFF);
`endif

        for (int c = 0; c < 3; c++) cycle(0, 0, 0, 4'b1111, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/distributor_fixed_shiftable.md
Name: distributor_fixed_shiftable

Overview:
- 1-to-N stream distributor; the inverse of the N-to-1 fixed-priority shiftable arbiter on the same valid/ready interface.
- Steers each accepted input beat to exactly one output lane: the highest-priority lane able to take it.
- Each lane has a one-entry registered output buffer.
- Priority order is a fixed rotation whose lowest-priority lane advances by one on each `shift` pulse.
- Used to fan a single producer out to N parallel consumers/workers.

Parameters:
- DWIDTH, 20, payload width in bits.
- N, 2, number of output lanes; must be >= 2.
- INIT_LOWEST_PRIO, N-1, lowest-priority lane index after reset; must be in 0..N-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_data  input  DWIDTH  input payload.
- in_ready  output  1  distributor can accept the input beat this cycle.
- shift  input  1  advance lowest-priority pointer by one lane.
- out_valid  output  1 x [N-1:0] (unpacked)  lane buffer holds a beat.
- out_data  output  DWIDTH x [N-1:0] (unpacked)  lane payload.
- out_ready  input  1 x [N-1:0] (unpacked)  lane consumer accepts.

Behaviour:
- State:
  - per-lane buffer: vld[i], dat[i];
  - pointer lp, width $clog2(N), holding the lowest-priority lane index.
- Reset (rst=1 at edge): vld[i]=0, dat[i]=0, lp=INIT_LOWEST_PRIO. While rst is high, in_ready=0.
- Lane availability: avail[i] = !vld[i] | out_ready[i]. A full lane being drained this cycle may be reloaded in the same cycle, so there is no bubble.
- Priority scan: highest priority is lane (lp+1) mod N, then (lp+2) mod N, ..., ending at lp.
  - sel = first lane in scan order with avail=1.
  - Scan is combinational; wrap-around via modulo N. N need not be a power of two; the pointer wraps from N-1 to 0.
- in_ready = |avail (combinational from vld, out_ready and rst). It must not depend on in_valid.
- Transfer: when in_valid & in_ready, at the edge dat[sel] <= in_data and vld[sel] <= 1.
- Drain: when vld[i] & out_ready[i] and lane i is not loaded this cycle, vld[i] <= 0. dat[i] holds its value (no clear).
- Simultaneous drain and load on the same lane: the lane stays valid with the new data.
- Exactly one lane is loaded per transfer. Never duplicate a beat; never drop one.
- Latency: the input beat appears on out_valid/out_data of its lane on the cycle after acceptance.
- Shift: if shift=1 at an edge, lp <= (lp+1) mod N.
  - A transfer in the same cycle uses the pre-shift lp.
  - Shift is independent of traffic and is honoured even when in_valid=0.
- Output stability: a valid lane beat holds out_data stable until out_ready, per the standard valid/ready rule.
- All lanes full with no out_ready: in_ready=0; input stalls; no state changes except shift.
- Mid-operation reset: buffered beats are discarded; lp returns to INIT_LOWEST_PRIO.

Optional Feature:
- Macro: DISTRIBUTOR_STATS_EN.
- Defined:
  - adds output port lane_count, 16 bits x [N-1:0] (unpacked);
  - one counter per lane, +1 on each load into that lane;
  - saturates at 16'hFFFF;
  - cleared by rst.
- Undefined: the port and counters are absent; function is otherwise identical.

Test Plan:
- Reset priority: N=4, INIT_LOWEST_PRIO=3, all out_ready=1, send D0=0x11 -> lane 0 valid with 0x11 on the next cycle; in_ready=1 throughout.
- Fill order: N=4, lp=3, all out_ready=0, send 5 beats 0xA..0xE -> lanes 0,1,2,3 hold 0xA,0xB,0xC,0xD; in_ready=0 after the fourth acceptance; 0xE is held at the input until out_ready[2]=1, then 0xE loads lane 2 the next cycle.
- Shift with transfer: N=2, lp=1, shift=1 and a beat 0x5 in the same cycle -> 0x5 goes to lane 0; the next beat 0x6 with all lanes free goes to lane 1 (lp now 0); a second shift wraps lp to 1.
- Same-cycle drain/reload: N=2, lane 0 full with 0x1, lane 1 full, out_ready={0,1}, beat 0x2 arrives -> lane 0 reloaded with 0x2, vld[0] stays 1, lane 1 unchanged, no beat lost.
- Reset mid-stream: two lanes full, assert rst for 1 cycle -> all out_valid=0 and in_ready=0 during rst; after release lp=INIT_LOWEST_PRIO, and the first beat goes to lane (INIT_LOWEST_PRIO+1) mod N.
- Stats (DISTRIBUTOR_STATS_EN): 3 beats to lane 0 and 1 to lane 1 -> lane_count = {1,3}; force 70000 loads into one lane -> that counter reads 16'hFFFF.
